montgomery_modexp_ctrl: RTL and testbench

Sequential controller that computes base^exp mod modulant using left-to-right square-and-multiply in the Montgomery domain. It time-multiplexes one 2*DATA_WIDTH multiplier and one montgomery_reduce datapath instance, and issues exactly one multiply or reduce per cycle. Software supplies operands already converted to Montgomery form. The block sits between the register/bus interface and the montgomery_reduce datapath, and is the only sequencer of that datapath.

---
 rtl/montgomery_modexp_ctrl.sv | 150 +++++++++++++++
 tb/tb_montgomery_modexp_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/montgomery_modexp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery domain.
// One shared multiplier and one reduce stage, one operation per cycle.
module montgomery_modexp_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned EXP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] base_mont,
  input  logic [DATA_WIDTH-1:0] r_mod_n,
  input  logic [EXP_WIDTH-1:0]  exponent,
  input  logic [DATA_WIDTH-1:0] modulant,
  input  logic [DATA_WIDTH-1:0] R_div_two,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned IdxW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    StIdle, StSqrMul, StSqrRed, StMpyMul, StMpyRed, StConvMul, StConvRed, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [W-1:0]        acc_q, acc_d;
  logic [2*W-1:0]      prod_q, prod_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [W-1:0]        base_q, base_d;
  logic [W-1:0]        mod_q, mod_d;
  logic [W-1:0]        rdt_q, rdt_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [W-1:0]        result_q, result_d;
  logic [W-1:0]        mul_b;
  logic [W-1:0]        red;
  logic                unused_rdt;

  // REDC with R = 2^W: W halving steps (adding n when odd), then one conditional subtract.
  function automatic logic [W-1:0] mont_reduce(input logic [2*W-1:0] p, input logic [W-1:0] n);
    logic [2*W:0] t;
    t = {1'b0, p};
    for (int i = 0; i < int'(W); i++) begin
      if (t[0]) t = t + {{(W + 1){1'b0}}, n};
      t = t >> 1;
    end
    if (t >= {{(W + 1){1'b0}}, n}) t = t - {{(W + 1){1'b0}}, n};
    return t[W-1:0];
  endfunction

  assign red        = mont_reduce(prod_q, mod_q);
  // R/2 is latched for the datapath interface; the bit-serial reduce derives R from W.
  assign unused_rdt = ^rdt_q;

  always_comb begin
    unique case (state_q)
      StMpyMul:  mul_b = base_q;
      StConvMul: mul_b = {{(W - 1){1'b0}}, 1'b1};
      default:   mul_b = acc_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    idx_d    = idx_q;
    base_d   = base_q;
    mod_d    = mod_q;
    rdt_d    = rdt_q;
    exp_d    = exp_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_mont;
          exp_d   = exponent;
          mod_d   = modulant;
          rdt_d   = R_div_two;
          acc_d   = r_mod_n;
          idx_d   = IdxW'(EXP_WIDTH - 1);
          state_d = StSqrMul;
        end
      end
      StSqrMul, StMpyMul, StConvMul: begin
        prod_d = {{W{1'b0}}, acc_q} * {{W{1'b0}}, mul_b};
        unique case (state_q)
          StSqrMul: state_d = StSqrRed;
          StMpyMul: state_d = StMpyRed;
          default:  state_d = StConvRed;
        endcase
      end
      StSqrRed: begin
        acc_d = red;
        if (exp_q[idx_q]) begin
          state_d = StMpyMul;
        end else if (idx_q == '0) begin
          state_d = StConvMul;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StSqrMul;
        end
      end
      StMpyRed: begin
        acc_d = red;
        if (idx_q == '0) begin
          state_d = StConvMul;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StSqrMul;
        end
      end
      StConvRed: begin
        result_d = red;
        state_d  = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      prod_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      rdt_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      rdt_q    <= rdt_d;
      exp_q    <= exp_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_montgomery_modexp_ctrl.sv
// Directed-vector bench for montgomery_modexp_ctrl; expected results hand-computed.
module tb_montgomery_modexp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_mont, r_mod_n, modulant, R_div_two;
  logic [3:0] exponent;
  logic       busy, done;
  logic [7:0] result;

  int errors = 0;
  int checks = 0;

  montgomery_modexp_ctrl #(.DATA_WIDTH(8), .EXP_WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_mont (base_mont),
    .r_mod_n   (r_mod_n),
    .exponent  (exponent),
    .modulant  (modulant),
    .R_div_two (R_div_two),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run, counts edges to the done pulse, checks latency, busy and result.
  // With mid set, a second start with other operands is pulsed partway through.
  task automatic run(input string tag, input logic [7:0] b, input logic [7:0] rn,
                     input logic [3:0] e, input logic [7:0] m,
                     input int exp_res, input int exp_lat, input bit mid);
    int  n;
    bit  busy_low;
    base_mont = b;
    r_mod_n   = rn;
    exponent  = e;
    modulant  = m;
    R_div_two = 8'd128;
    start     = 1'b1;
    tick();
    start    = 1'b0;
    n        = 0;
    busy_low = 1'b0;
    while (!done && n < 64) begin
      if (!busy) busy_low = 1'b1;
      if (mid && n == 3) begin
        start     = 1'b1;
        base_mont = 8'd7;
        exponent  = 4'd3;
        modulant  = 8'd11;
        r_mod_n   = 8'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check_eq({tag, " latency"}, n, exp_lat);
    check_eq({tag, " result"}, int'(result), exp_res);
    check_eq({tag, " busy held"}, int'(busy_low), 0);
    check_eq({tag, " busy at done"}, int'(busy), 0);
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    start     = 1'b0;
    base_mont = '0;
    r_mod_n   = '0;
    exponent  = '0;
    modulant  = '0;
    R_div_two = 8'd128;
    tick();
    tick();
    check_eq("reset busy", int'(busy), 0);
    check_eq("reset done", int'(done), 0);
    check_eq("reset result", int'(result), 0);
    reset = 1'b0;
    tick();

    // n=13, R mod n = 9, 2*R mod n = 5
    run("exp5", 8'd5, 8'd9, 4'd5, 8'd13, 6, 14, 1'b0);
    tick();
    run("exp15", 8'd5, 8'd9, 4'd15, 8'd13, 8, 18, 1'b0);
    tick();
    run("exp0", 8'd5, 8'd9, 4'd0, 8'd13, 1, 10, 1'b0);
    tick();
    // n=11, R mod n = 3, 3*R mod n = 9
    run("b3e13", 8'd9, 8'd3, 4'd13, 8'd11, 5, 16, 1'b0);
    tick();

    run("midstart", 8'd5, 8'd9, 4'd5, 8'd13, 6, 14, 1'b1);
    // start during the done cycle must be ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start in done ignored", int'(busy), 0);
    check_eq("result held", int'(result), 6);
    run("after done", 8'd9, 8'd3, 4'd13, 8'd11, 5, 16, 1'b0);
    tick();

    // reset mid-run
    base_mont = 8'd5;
    r_mod_n   = 8'd9;
    exponent  = 4'd15;
    modulant  = 8'd13;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("busy before reset", int'(busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("midreset busy", int'(busy), 0);
    check_eq("midreset result", int'(result), 0);
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      if (done) pulses++;
      tick();
    end
    check_eq("midreset no done", pulses, 0);
    run("post reset", 8'd5, 8'd9, 4'd5, 8'd13, 6, 14, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
